// File: rtl/bar_region_seq.sv
// Vertical bar-region sequencer: tracks frame/line strobes and flags which bar band the current line falls in.
// Optional macro BAR_REGION_GAP_EN inserts BAR_GAP blank lines between consecutive bars.
module bar_region_seq #(
    parameter int unsigned           NUM_BARS  = 16,
    parameter int unsigned           BAR_H     = 32,
    parameter int unsigned           TOP_OFS   = 15,
    parameter int unsigned           BAR_GAP   = 2,
    parameter logic [NUM_BARS-1:0]   SKIP_MASK = '0,
    localparam int unsigned          IDX_W     = $clog2(NUM_BARS)
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                iFRAME_STB,
    input  logic                iLINE_STB,
    output logic                oIN_BAR,
    output logic [NUM_BARS-1:0] oBAR,
    output logic [IDX_W-1:0]    oBAR_IDX,
    output logic                oBAR_FIRST,
    output logic                oFRAME_DONE
);

    localparam logic [9:0]       TOP_LAST = (TOP_OFS == 0) ? 10'd0 : 10'(TOP_OFS - 1);
    localparam logic [9:0]       BAR_LAST = 10'(BAR_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BARS - 1);
    localparam logic [NUM_BARS-1:0] ONE   = NUM_BARS'(1);

    if (NUM_BARS < 2 || NUM_BARS > 64 || BAR_H < 1 || BAR_H > 255 ||
        TOP_OFS > 1023 || BAR_GAP < 1 || BAR_GAP > 15) begin : g_param_check
        $error("bar_region_seq: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        BAR,
`ifdef BAR_REGION_GAP_EN
        GAP,
`endif
        DONE
    } state_t;

`ifdef BAR_REGION_GAP_EN
    localparam logic [9:0] GAP_LAST = 10'(BAR_GAP - 1);
`endif

    state_t           state, state_n;
    logic [9:0]       cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             done_n;

    // Frame strobe takes priority over a coincident line strobe.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        done_n  = 1'b0;
        if (iFRAME_STB) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = (TOP_OFS == 0) ? BAR : TOP;
        end else if (iLINE_STB) begin
            case (state)
                TOP: begin
                    if (cnt == TOP_LAST) begin
                        state_n = BAR;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 10'd1;
                    end
                end
                BAR: begin
                    if (cnt == BAR_LAST) begin
                        cnt_n = '0;
                        if (idx == IDX_LAST) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
`ifdef BAR_REGION_GAP_EN
                            state_n = GAP;
`else
                            idx_n   = idx + 1'b1;
`endif
                        end
                    end else begin
                        cnt_n = cnt + 10'd1;
                    end
                end
`ifdef BAR_REGION_GAP_EN
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = BAR;
                        idx_n   = idx + 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 10'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            oIN_BAR     <= 1'b0;
            oBAR        <= '0;
            oBAR_IDX    <= '0;
            oBAR_FIRST  <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            oIN_BAR     <= (state_n == BAR);
            oBAR        <= (state_n == BAR) ? ((ONE << idx_n) & ~SKIP_MASK) : '0;
            oBAR_IDX    <= idx_n;
            oBAR_FIRST  <= (state_n == BAR) && (cnt_n == 10'd0);
            oFRAME_DONE <= done_n;
        end
    end

endmodule

// File: tb/tb_bar_region_seq.sv
// Self-checking bench for bar_region_seq: two configurations driven by shared strobes,
// compared each cycle against a line-number based reference model.
module tb_bar_region_seq;

`ifdef BAR_REGION_GAP_EN
    localparam int GAP_A = 2;
    localparam int GAP_B = 1;
`else
    localparam int GAP_A = 0;
    localparam int GAP_B = 0;
`endif

    logic clk = 1'b0;
    logic rst_n, fs, ls;

    logic        a_in_bar, a_first, a_done;
    logic [15:0] a_bar;
    logic [3:0]  a_idx;
    logic        b_in_bar, b_first, b_done;
    logic [3:0]  b_bar;
    logic [1:0]  b_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: configuration, strobes since frame start, activity, done pulse
    int          nb[2], bh[2], to[2], gp[2];
    logic [63:0] mk[2];
    int          lines[2];
    bit          act[2];
    bit          dp[2];

    always #5 clk = ~clk;

    bar_region_seq dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iFRAME_STB(fs), .iLINE_STB(ls),
        .oIN_BAR(a_in_bar), .oBAR(a_bar), .oBAR_IDX(a_idx),
        .oBAR_FIRST(a_first), .oFRAME_DONE(a_done)
    );

    bar_region_seq #(
        .NUM_BARS(4), .BAR_H(2), .TOP_OFS(0), .BAR_GAP(1), .SKIP_MASK(4'b0010)
    ) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iFRAME_STB(fs), .iLINE_STB(ls),
        .oIN_BAR(b_in_bar), .oBAR(b_bar), .oBAR_IDX(b_idx),
        .oBAR_FIRST(b_first), .oFRAME_DONE(b_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int total_lines(input int i);
        return to[i] + nb[i] * bh[i] + (nb[i] - 1) * gp[i];
    endfunction

    function automatic void expect_of(input int i, output bit inb, output logic [63:0] bar,
                                      output logic [63:0] idx, output bit first);
        int p, per, k, r;
        inb = 0; bar = '0; idx = '0; first = 0;
        if (!act[i] || lines[i] < to[i]) return;
        if (lines[i] >= total_lines(i)) begin
            idx = 64'(nb[i] - 1);
            return;
        end
        p   = lines[i] - to[i];
        per = bh[i] + gp[i];
        k   = p / per;
        r   = p % per;
        idx = 64'(k);
        if (r < bh[i]) begin
            inb   = 1;
            first = (r == 0);
            bar   = (64'd1 << k) & ~mk[i];
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; lines[i] = 0; dp[i] = 0;
        end
    endtask

    task automatic model_step(input bit f, input bit l);
        for (int i = 0; i < 2; i++) begin
            dp[i] = 0;
            if (!rst_n) begin
                act[i] = 0; lines[i] = 0;
            end else if (f) begin
                act[i] = 1; lines[i] = 0;
            end else if (l && act[i] && lines[i] < total_lines(i)) begin
                lines[i]++;
                if (lines[i] == total_lines(i)) dp[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        bit inb, first;
        logic [63:0] bar, idx;
        expect_of(0, inb, bar, idx, first);
        check_eq("a_in_bar", 64'(a_in_bar), 64'(inb));
        check_eq("a_bar",    64'(a_bar),    bar);
        check_eq("a_idx",    64'(a_idx),    idx);
        check_eq("a_first",  64'(a_first),  64'(first));
        check_eq("a_done",   64'(a_done),   64'(dp[0]));
        expect_of(1, inb, bar, idx, first);
        check_eq("b_in_bar", 64'(b_in_bar), 64'(inb));
        check_eq("b_bar",    64'(b_bar),    bar);
        check_eq("b_idx",    64'(b_idx),    idx);
        check_eq("b_first",  64'(b_first),  64'(first));
        check_eq("b_done",   64'(b_done),   64'(dp[1]));
    endtask

    task automatic cycle(input bit f, input bit l);
        fs = f; ls = l;
        @(posedge clk);
        #1;
        fs = 0; ls = 0;
        model_step(f, l);
        check_all();
        @(negedge clk);
    endtask

    task automatic run_to_bar(input int target, output bit reached);
        bit inb, first;
        logic [63:0] bar, idx;
        reached = 0;
        for (int n = 0; n < 2000 && !reached; n++) begin
            cycle(0, 1);
            expect_of(0, inb, bar, idx, first);
            if (inb && idx == 64'(target)) reached = 1;
        end
    endtask

    initial begin
        bit reached;
        nb[0] = 16; bh[0] = 32; to[0] = 15; gp[0] = GAP_A; mk[0] = 64'h0;
        nb[1] = 4;  bh[1] = 2;  to[1] = 0;  gp[1] = GAP_B; mk[1] = 64'h2;
        fs = 0; ls = 0; rst_n = 0;
        model_reset();
        #1;
        check_all();
        cycle(0, 1);
        @(negedge clk);
        rst_n = 1;

        // Line strobes before any frame strobe must not start bars
        repeat (5) cycle(0, 1);

        // Full frame with continuous line strobes, then extra strobes after DONE
        cycle(1, 0);
        repeat (600) cycle(0, 1);

        // Full frame with irregular line strobe spacing
        cycle(1, 1);
        repeat (900) cycle(0, ($urandom_range(0, 3) != 0));

        // Coincident frame and line strobe in the middle of bar 5
        cycle(1, 0);
        run_to_bar(5, reached);
        check_eq("reach_bar5", 64'(reached), 64'd1);
        repeat (3) cycle(0, 1);
        cycle(1, 1);
        repeat (4) cycle(0, 1);

        // Asynchronous reset in bar 7, then line strobes only
        cycle(1, 0);
        run_to_bar(7, reached);
        check_eq("reach_bar7", 64'(reached), 64'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        repeat (3) cycle(0, 1);
        rst_n = 1;
        repeat (40) cycle(0, 1);

        // Random strobes
        for (int n = 0; n < 4000; n++)
            cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bar_region_seq.md
BAR_REGION_SEQ -- requirements
Module: bar_region_seq

Interface
REQ-001 SHALL provide parameter NUM_BARS, default 16, number of vertical bar regions (2..64).
REQ-002 SHALL provide parameter BAR_H, default 32, lines per bar (1..255).
REQ-003 SHALL provide parameter TOP_OFS, default 15, blank lines from frame start to bar 0 (0..1023).
REQ-004 SHALL provide parameter BAR_GAP, default 2, blank lines between bars (1..15); used only with gap feature.
REQ-005 SHALL provide parameter SKIP_MASK, default 0, NUM_BARS-bit mask; set bit suppresses that bar's one-hot output.
REQ-006 SHALL provide localparam IDX_W = clog2(NUM_BARS).
REQ-007 iCLK  input  1  sole clock, all logic rising-edge.
REQ-008 iRST_N  input  1  asynchronous active-low reset.
REQ-009 iFRAME_STB  input  1  one-cycle pulse at start of each frame (line 0).
REQ-010 iLINE_STB  input  1  one-cycle pulse at end of each displayed line.
REQ-011 oIN_BAR  output  1  current line lies inside a bar.
REQ-012 oBAR  output  NUM_BARS  one-hot active bar, masked by SKIP_MASK, zero outside bars.
REQ-013 oBAR_IDX  output  IDX_W  index of current/last bar.
REQ-014 oBAR_FIRST  output  1  high during the first line of each bar.
REQ-015 oFRAME_DONE  output  1  one-cycle pulse when the last bar's last line completes.

Function
REQ-016 SHALL implement states IDLE, TOP, BAR, GAP, DONE with an internal line counter (10 bits) and bar index register.
REQ-017 iFRAME_STB in any state SHALL clear counter, idx to 0, and enter TOP, or BAR directly when TOP_OFS=0.
REQ-018 In TOP, iLINE_STB with counter=TOP_OFS-1 SHALL enter BAR with counter 0; otherwise counter increments.
REQ-019 In BAR, iLINE_STB with counter=BAR_H-1 SHALL: if idx=NUM_BARS-1 enter DONE and pulse oFRAME_DONE; else enter GAP (gap feature) or BAR with idx+1; counter resets to 0.
REQ-020 In GAP, iLINE_STB with counter=BAR_GAP-1 SHALL enter BAR with idx+1, counter 0.
REQ-021 DONE and IDLE SHALL ignore iLINE_STB.
REQ-022 iFRAME_STB and iLINE_STB in the same cycle: frame strobe SHALL win; line strobe discarded.
REQ-023 All outputs SHALL be registered; they reflect the state one cycle after the strobe that caused the transition.
REQ-024 oIN_BAR SHALL be 1 iff state=BAR; oBAR = (1<<idx) & ~SKIP_MASK when in BAR, else 0.
REQ-025 oBAR_FIRST SHALL be 1 iff state=BAR and counter=0.
REQ-026 Bar regions SHALL be half-open: no line belongs to two bars (bar k occupies BAR_H lines exactly).
REQ-027 oBAR_IDX SHALL hold its value in GAP and DONE; return to 0 only on frame strobe or reset.

Reset
REQ-028 Assertion of iRST_N low SHALL immediately force state IDLE, counter 0, idx 0, all outputs 0.
REQ-029 Reset released mid-frame SHALL keep IDLE until the next iFRAME_STB; no partial-frame bars.

Configuration
REQ-030 Macro BAR_REGION_GAP_EN: defined -> GAP state used, BAR_GAP blank lines between consecutive bars; undefined -> GAP state absent, bars contiguous, BAR_GAP ignored.

Verification
REQ-031 Defaults, gap off: frame strobe then 15 line strobes -> oIN_BAR=1, oBAR=0x0001, oBAR_FIRST=1; after 32 more -> oBAR=0x0002.
REQ-032 Defaults, gap off: 15+16*32=527 line strobes -> oFRAME_DONE single pulse, oIN_BAR=0, oBAR_IDX=15; further strobes no change.
REQ-033 BAR_REGION_GAP_EN, BAR_GAP=2: after line 47 oIN_BAR=0 for exactly 2 lines, then oBAR=0x0002; last bar ends after 15+16*32+15*2=557 strobes.
REQ-034 SKIP_MASK=0x0002: in bar 1 -> oIN_BAR=1, oBAR=0, oBAR_IDX=1.
REQ-035 Frame and line strobes in same cycle while in bar 5 -> next cycle state TOP, counter 0, oBAR=0, oBAR_IDX=0.
REQ-036 iRST_N low in bar 7, released, line strobes only -> outputs stay 0 until next iFRAME_STB.
